uart_word_serializer: RTL and testbench
=======================================

Name: uart_word_serializer

Overview:
Upstream feeder for the UART byte transmitter. It accepts one WORD_W-bit result word (e.g. an RSA ciphertext or plaintext) on a valid/ready handshake. It splits the word into bytes, most-significant byte first, and issues one tx_start pulse per byte. It uses the transmitter's tx_busy to pace itself, so no byte is dropped or overwritten.

Parameters:
WORD_W, 32, width of the input word in bits; must be a multiple of 8 and at least 8 (elaboration-time assertion).
NBYTES, WORD_W/8, localparam, bytes per word.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream word valid
in_ready  output  1  block can accept a word (high only in IDLE)
in_data  input  WORD_W  word to transmit; sampled on in_valid & in_ready
tx_start  output  1  one-cycle start pulse to the UART transmitter
tx_data  output  8  byte to transmit; stable from the tx_start cycle until tx_busy falls
tx_busy  input  1  UART transmitter busy; rises the cycle after tx_start is sampled
busy  output  1  high from word acceptance until the last byte completes
done  output  1  one-cycle pulse when the final byte's tx_busy falls

Behaviour:
- Reset (async assert, sync release): state=IDLE, in_ready=1, tx_start=0, tx_data=8'h00, busy=0, done=0, byte counter=0, shift register=0.
- All outputs are registered except in_ready, which is decoded from state==IDLE.
- IDLE: on in_valid & in_ready, latch in_data into the shift register, set counter=0 and busy=1, then go to ARM. Otherwise stay in IDLE.
- ARM: wait until tx_busy==0. In the first cycle with tx_busy==0, register tx_start=1 and tx_data=shift[WORD_W-1 -: 8], then go to WAIT_HI.
  - tx_start is therefore high for exactly one cycle, starting the cycle after the ARM decision.
- WAIT_HI: tx_start=0. Wait for tx_busy==1, then go to WAIT_LO.
- WAIT_LO: wait for tx_busy==0.
  - If counter==NBYTES-1: go to IDLE, pulse done, clear busy.
  - Else: shift left by 8, increment counter, go to ARM.
- Latency: acceptance edge to first tx_start high = 1 cycle when tx_busy is already low.
  - Gap between the fall of tx_busy and the next tx_start = 2 cycles (WAIT_LO→ARM, ARM→pulse).
- Simultaneous in_valid and busy: in_ready=0 and the word is not taken; upstream must hold in_valid and in_data.
- tx_busy already high on entry to ARM (a foreign frame): stall, with no pulse, until it drops.
- A new word is accepted no earlier than the cycle after done.
- Reset mid-word: all state is cleared and the partial word is discarded. The UART frame in flight is not this block's concern.
- Counter width is $clog2(NBYTES+1) bits; it never wraps within a word.
- tx_data holds its last value in IDLE.

Optional Feature:
UART_WORD_CHKSUM_EN
- Defined: a running XOR of all NBYTES data bytes is kept. After the last data byte, one extra byte equal to that XOR is sent through the same ARM/WAIT_HI/WAIT_LO sequence. done pulses after the checksum byte.
- Not defined: exactly NBYTES bytes are sent, and no checksum logic exists.

Decomposition:
- Package uart_pkg:
  - state enum (IDLE, ARM, WAIT_HI, WAIT_LO);
  - localparam BYTE_W=8;
  - function chksum_step(acc, byte) returning acc^byte.
- No sub-module. The uart_tx instance lives in the parent. The bench pairs this block with a behavioural uart_tx model using a short BIT_PERIOD.

Test Plan:
- WORD_W=32, in_data=32'hDEADBEEF, single in_valid pulse -> tx_data sequence DE, AD, BE, EF.
  - Exactly 4 one-cycle tx_start pulses.
  - done once, after the 4th tx_busy fall.
  - in_ready low throughout.
- Back-to-back words 32'h01020304 then 32'hA5A5A5A5, with in_valid held -> second word accepted the cycle after done; 8 bytes sent in order, none dropped.
- tx_busy forced high for 50 cycles before the first byte -> tx_start stays 0 until tx_busy falls; pulse 2 cycles later; data is 8'hDE.
- rst_n asserted while in WAIT_LO of byte 2 -> same cycle: tx_start=0, busy=0, in_ready=1. After release, a new word 32'h11223344 sends 11, 22, 33, 44.
- UART_WORD_CHKSUM_EN defined, 32'hDEADBEEF -> 5 bytes: DE, AD, BE, EF, 22; done after the 5th.
- WORD_W=8, in_data=8'h7E -> single tx_start with tx_data=7E, then done; no shift occurs.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART word serializer.
package uart_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StWaitHi,
    StWaitLo
  } state_e;

  function automatic logic [BYTE_W-1:0] chksum_step(input logic [BYTE_W-1:0] acc,
                                                    input logic [BYTE_W-1:0] data);
    return acc ^ data;
  endfunction

endpackage

// File: rtl/uart_word_serializer.sv
// Splits a WORD_W-bit word into MSB-first bytes paced by the UART transmitter's tx_busy.
// Optional UART_WORD_CHKSUM_EN appends an XOR checksum byte after the data bytes.
module uart_word_serializer
  import uart_pkg::*;
#(
  parameter int unsigned WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic              busy,
  output logic              done
);

  localparam int unsigned NBYTES = WORD_W / BYTE_W;
  localparam int unsigned CntW   = $clog2(NBYTES + 1);
`ifdef UART_WORD_CHKSUM_EN
  localparam int unsigned LastIdx = NBYTES;
`else
  localparam int unsigned LastIdx = NBYTES - 1;
`endif

  if ((WORD_W % BYTE_W) != 0 || WORD_W < BYTE_W) begin : g_bad_width
    $error("uart_word_serializer: WORD_W must be a nonzero multiple of 8");
  end

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   shift_q, shift_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                tx_start_q, tx_start_d;
  logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
`ifdef UART_WORD_CHKSUM_EN
  logic [BYTE_W-1:0]   chk_q, chk_d;
`endif

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
`ifdef UART_WORD_CHKSUM_EN
    chk_d      = chk_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          shift_d = in_data;
          cnt_d   = '0;
          busy_d  = 1'b1;
`ifdef UART_WORD_CHKSUM_EN
          chk_d   = '0;
`endif
          state_d = StArm;
        end
      end
      StArm: begin
        // A busy transmitter here may be a foreign frame: hold off until it drops.
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = shift_q[WORD_W-1 -: BYTE_W];
`ifdef UART_WORD_CHKSUM_EN
          if (cnt_q != CntW'(NBYTES)) begin
            chk_d = chksum_step(chk_q, shift_q[WORD_W-1 -: BYTE_W]);
          end
`endif
          state_d = StWaitHi;
        end
      end
      StWaitHi: begin
        if (tx_busy) begin
          state_d = StWaitLo;
        end
      end
      StWaitLo: begin
        if (!tx_busy) begin
          if (cnt_q == CntW'(LastIdx)) begin
            state_d = StIdle;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
`ifdef UART_WORD_CHKSUM_EN
          else if (cnt_q == CntW'(NBYTES - 1)) begin
            // Checksum rides in the top byte so ARM sends it like any data byte.
            shift_d = WORD_W'(chk_q) << (WORD_W - BYTE_W);
            cnt_d   = cnt_q + 1'b1;
            state_d = StArm;
          end
`endif
          else begin
            shift_d = shift_q << BYTE_W;
            cnt_d   = cnt_q + 1'b1;
            state_d = StArm;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      cnt_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef UART_WORD_CHKSUM_EN
      chk_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef UART_WORD_CHKSUM_EN
      chk_q      <= chk_d;
`endif
    end
  end

  assign in_ready = (state_q == StIdle);
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_uart_word_serializer.sv
// Bench for uart_word_serializer paired with a behavioural UART transmitter busy model.
module tb_uart_word_serializer;

  localparam int FRAME = 6;
`ifdef UART_WORD_CHKSUM_EN
  localparam int NB  = 5;
  localparam int NB8 = 2;
`else
  localparam int NB  = 4;
  localparam int NB8 = 1;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, tx_start, tx_busy, busy, done;
  logic [31:0] in_data;
  logic [7:0]  tx_data;

  logic        in_valid8, in_ready8, tx_start8, tx_busy8, busy8, done8;
  logic [7:0]  in_data8, tx_data8;

  uart_word_serializer #(.WORD_W(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .busy     (busy),
    .done     (done)
  );

  uart_word_serializer #(.WORD_W(8)) dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid8),
    .in_ready (in_ready8),
    .in_data  (in_data8),
    .tx_start (tx_start8),
    .tx_data  (tx_data8),
    .tx_busy  (tx_busy8),
    .busy     (busy8),
    .done     (done8)
  );

  int tests = 0;
  int fails = 0;

  // Transmitter model: busy rises the cycle after tx_start is sampled, lasts FRAME cycles.
  logic busy_m = 1'b0;
  logic force_busy = 1'b0;
  int   busy_left = 0;
  assign tx_busy = busy_m | force_busy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_m <= 1'b0; busy_left <= 0;
    end else if (tx_start) begin
      busy_m <= 1'b1; busy_left <= FRAME;
    end else if (busy_left > 1) begin
      busy_left <= busy_left - 1;
    end else begin
      busy_m <= 1'b0; busy_left <= 0;
    end
  end

  logic [7:0] cap_q[$];
  int         gap_q[$];
  int         cyc = 0, fall_cyc = 0, done_cnt = 0, done_cyc = 0, rise_cyc = 0, viol = 0;
  logic       prev_busy = 1'b0, prev_start = 1'b0, prev_dbusy = 1'b0;
  logic [7:0] last_tx = 8'h00;

  always @(posedge clk) begin
    cyc        <= cyc + 1;
    prev_busy  <= tx_busy;
    prev_start <= tx_start;
    prev_dbusy <= busy;
    if (prev_busy && !tx_busy) fall_cyc <= cyc;
    if (tx_start) begin
      cap_q.push_back(tx_data);
      gap_q.push_back(cyc - fall_cyc);
      last_tx <= tx_data;
    end
    viol <= viol + int'(tx_start && prev_start) + int'(busy && in_ready)
                 + int'(busy_m && (tx_data != last_tx));
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (!prev_dbusy && busy) rise_cyc <= cyc;
  end

  logic       busy8_m = 1'b0;
  int         left8 = 0;
  logic [7:0] cap8_q[$];
  int         done8_cnt = 0;
  assign tx_busy8 = busy8_m;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy8_m <= 1'b0; left8 <= 0;
    end else if (tx_start8) begin
      busy8_m <= 1'b1; left8 <= FRAME;
    end else if (left8 > 1) begin
      left8 <= left8 - 1;
    end else begin
      busy8_m <= 1'b0; left8 <= 0;
    end
  end

  always @(posedge clk) begin
    if (tx_start8) cap8_q.push_back(tx_data8);
    if (done8) done8_cnt <= done8_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    for (int i = 0; i < 2000 && !in_ready; i++) @(negedge clk);
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_done(input int d0, input string name);
    for (int i = 0; i < 2000 && done_cnt == d0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check({name, "_done_count"}, 32'(done_cnt), 32'(d0 + 1));
  endtask

  task automatic check_bytes(input string name, input logic [7:0] exp[$]);
    check({name, "_nbytes"}, 32'(cap_q.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < cap_q.size(); i++)
      check($sformatf("%s_byte%0d", name, i), 32'(cap_q[i]), 32'(exp[i]));
  endtask

  typedef struct {
    logic [31:0] word;
    logic [39:0] bytes;  // data bytes MSB first, then the XOR checksum
  } vec_t;

  vec_t       vec[6];
  logic [7:0] exp_q[$];
  int         d0, v0, dc1;

  initial begin
    vec[0] = '{32'hDEADBEEF, 40'hDEADBEEF22};
    vec[1] = '{32'h01020304, 40'h0102030404};
    vec[2] = '{32'hA5A5A5A5, 40'hA5A5A5A500};
    vec[3] = '{32'h00000000, 40'h0000000000};
    vec[4] = '{32'hFFFFFFFF, 40'hFFFFFFFF00};
    vec[5] = '{32'h80000001, 40'h8000000181};

    in_valid = 1'b0; in_data = '0; in_valid8 = 1'b0; in_data8 = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data",  32'(tx_data),  32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_done",     32'(done),     32'd0);
    check("rst_in_ready8", 32'(in_ready8), 32'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      cap_q.delete(); gap_q.delete(); exp_q.delete();
      d0 = done_cnt; v0 = viol;
      for (int i = 0; i < NB; i++) exp_q.push_back(vec[v].bytes[39 - 8*i -: 8]);
      send_word(vec[v].word);
      wait_done(d0, $sformatf("vec%0d", v));
      check_bytes($sformatf("vec%0d", v), exp_q);
      for (int i = 1; i < gap_q.size(); i++)
        check($sformatf("vec%0d_gap%0d", v, i), 32'(gap_q[i]), 32'd2);
      check($sformatf("vec%0d_protocol", v), 32'(viol - v0), 32'd0);
      check($sformatf("vec%0d_idle", v), {30'd0, busy, in_ready}, 32'd1);
    end

    // Back-to-back words with in_valid held across the first done.
    cap_q.delete(); exp_q.delete(); d0 = done_cnt; v0 = viol;
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h01020304;
    @(posedge clk);
    #1 in_data = 32'hA5A5A5A5;
    for (int i = 0; i < 2000 && !in_ready; i++) @(negedge clk);
    @(posedge clk);
    #1 in_valid = 1'b0;
    dc1 = done_cyc;
    check("b2b_first_done", 32'(done_cnt), 32'(d0 + 1));
    wait_done(d0 + 1, "b2b");
    check("b2b_busy_after_done", 32'(rise_cyc), 32'(dc1 + 1));
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
`ifdef UART_WORD_CHKSUM_EN
    exp_q.push_back(8'h04);
`endif
    exp_q.push_back(8'hA5); exp_q.push_back(8'hA5); exp_q.push_back(8'hA5); exp_q.push_back(8'hA5);
`ifdef UART_WORD_CHKSUM_EN
    exp_q.push_back(8'h00);
`endif
    check_bytes("b2b", exp_q);
    check("b2b_protocol", 32'(viol - v0), 32'd0);

    // Foreign frame holds tx_busy high before the first byte.
    cap_q.delete(); d0 = done_cnt;
    @(negedge clk) force_busy = 1'b1;
    send_word(32'hDEADBEEF);
    repeat (50) @(negedge clk);
    check("stall_no_pulse", 32'(cap_q.size()), 32'd0);
    force_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("stall_pulse_after_drop", 32'(cap_q.size()), 32'd1);
    if (cap_q.size() > 0) check("stall_first_byte", 32'(cap_q[0]), 32'hDE);
    wait_done(d0, "stall");
    check("stall_nbytes", 32'(cap_q.size()), 32'(NB));

    // Reset while waiting for byte 2's frame to end.
    cap_q.delete();
    send_word(32'hDEADBEEF);
    for (int i = 0; i < 2000 && cap_q.size() < 2; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("midrst_in_wait_lo", {30'd0, busy, tx_busy}, 32'd3);
    rst_n = 1'b0;
    #1;
    check("midrst_tx_start", 32'(tx_start), 32'd0);
    check("midrst_busy",     32'(busy),     32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_tx_data",  32'(tx_data),  32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    cap_q.delete(); d0 = done_cnt;
    send_word(32'h11223344);
    wait_done(d0, "postrst");
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
`ifdef UART_WORD_CHKSUM_EN
    exp_q.push_back(8'h44);
`endif
    check_bytes("postrst", exp_q);

    // Single-byte word: one data byte, no shifting.
    @(negedge clk);
    in_valid8 = 1'b1; in_data8 = 8'h7E;
    @(posedge clk);
    #1 in_valid8 = 1'b0;
    for (int i = 0; i < 2000 && done8_cnt == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("w8_done_count", 32'(done8_cnt), 32'd1);
    check("w8_nbytes", 32'(cap8_q.size()), 32'(NB8));
    for (int i = 0; i < cap8_q.size() && i < NB8; i++)
      check($sformatf("w8_byte%0d", i), 32'(cap8_q[i]), 32'h7E);
    check("w8_idle", {30'd0, busy8, in_ready8}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
